div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the EX stage; executes the DIV/DIVU ops issued by the ALU decoder.
- The EX stage asserts start_i when the decoded ALU control is a divide. The unit holds the pipeline via stall_o until the quotient and remainder are ready.
- result_o feeds the HI/LO write path: upper half is the remainder (HI), lower half is the quotient (LO).

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 162 ++++++++++++++++
 tb/tb_div_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The early-out shortcut is enabled by defining DIV_EARLY_OUT_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Quotient returned for a zero divisor; architecturally undefined, fixed for determinism.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  // result layout: {remainder (HI), quotient (LO)}
  localparam int HI_MSB = 2*DIV_WIDTH-1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int LO_MSB = DIV_WIDTH-1;
  localparam int LO_LSB = 0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift a dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i always holds, so the shifted value fits in WIDTH+1 bits
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
//
// Handshake: start_i is a level request sampled in IDLE when annul_i=0; the
// unit answers with stall_o until the result is ready, then a single-cycle
// ready_o pulse with result_o valid; result_o holds until the next ready_o.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o,
  output div_state_t         state_o
);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic             accept;
  logic             by_zero;
  logic             early;
  logic             last_step;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fix_quot, fix_rem;
  logic             nq, nr;
  logic [WIDTH-1:0] out_quot, out_rem;

  assign accept    = start_i & ~annul_i;
  assign by_zero   = (opdata2_i == '0);
  assign abs_a     = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs_b     = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign last_step = (cnt == CNT_W'(WIDTH-1));

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_q)
  );

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (by_zero)    state_nxt = BY_ZERO;
          else if (early) state_nxt = END;
          else            state_nxt = ON;
        end
      end
      BY_ZERO: state_nxt = annul_i ? IDLE : END;
      ON: begin
        if (annul_i)        state_nxt = IDLE;
        else if (last_step) state_nxt = END;
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    ready_o = (state == END);
    stall_o = ((state == IDLE) & accept) | (state == ON) | (state == BY_ZERO);
    state_o = state;
  end

  // Value that result_o captures on the edge entering END, before sign fix
  always_comb begin
    fix_quot = '0;
    fix_rem  = '0;
    nq       = 1'b0;
    nr       = 1'b0;
    case (state)
      IDLE: begin
        fix_rem = abs_a;
        nr      = signed_i & opdata1_i[WIDTH-1];
      end
      ON: begin
        fix_quot = {dvd_q[WIDTH-2:0], step_q};
        fix_rem  = step_rem;
        nq       = neg_quot_q;
        nr       = neg_rem_q;
      end
      BY_ZERO: begin
        fix_quot = WIDTH'(DIV_ZERO_QUOT);
        fix_rem  = dvd_q;
      end
      default: ;
    endcase
  end

  assign out_quot = nq ? -fix_quot : fix_quot;
  assign out_rem  = nr ? -fix_rem  : fix_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
    end else begin
      if (state_nxt == END) result_o <= {out_rem, out_quot};
      case (state)
        IDLE: begin
          if (accept) begin
            // a zero divisor reports the raw dividend, so keep it unmodified
            dvd_q      <= by_zero ? opdata1_i : abs_a;
            dvs_q      <= abs_b;
            rem_q      <= '0;
            cnt        <= '0;
            neg_quot_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_i & opdata1_i[WIDTH-1];
          end
        end
        ON: begin
          if (!annul_i) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[WIDTH-2:0], step_q};
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// divides checked against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;
  div_state_t  state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] last_exp;

  div_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  // cycles from the start cycle to the ready cycle
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(a, sgn) < mag(b, sgn)) return 1;
`endif
    return 33;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] exp;
    int exp_lat, lat, stalls;
    bit got;
    exp     = ref_div(a, b, sgn);
    exp_lat = ref_lat(a, b, sgn);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    #1;
    stalls = stall_o ? 1 : 0;
    @(posedge clk); #1;
    start_i = 1'b0; signed_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ready_o) got = 1'b1;
      else if (stall_o) stalls++;
    end
    check("ready_seen", 64'(got), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_cycles", 64'(stalls), 64'(exp_lat));
    check("stall_at_ready", 64'(stall_o), 64'd0);
    check("result", result_o, exp);
    @(negedge clk);
    check("ready_pulse", 64'(ready_o), 64'd0);
    check("result_hold", result_o, exp);
    last_exp = exp;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (ready_o) break;
    end
    check("ready_bound", 64'(ready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    int          lat, ready_seen;

    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; last_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(IDLE));
    resetn = 1'b1;

    // directed corner cases
    run_div(32'd100, 32'd7, 1'b0);
    check("divu_100_7", result_o, 64'h00000002_0000000E);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_m7_2", result_o, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div_overflow", result_o, 64'h00000000_80000000);
    run_div(32'd5, 32'd0, 1'b0);
    check("div_by_zero", result_o, 64'h00000005_FFFFFFFF);
    run_div(32'd3, 32'd10, 1'b0);
    check("divu_3_10", result_o, 64'h00000003_00000000);
    run_div(32'hFFFF_FFFD, 32'd10, 1'b1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);

    // random divides
    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 9))
        0:       begin b = 32'd0; sgn = 1'b0; end
        1, 2, 3: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (b == 32'd0 && sgn) b = 32'd3;
      if (sgn && $urandom_range(0, 1) == 1 && b != 32'd0) b = -b;
      run_div(a, b, sgn);
    end

    // annul on the 10th ON cycle: back to IDLE, no ready, result kept
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_state", 64'(state_o), 64'(IDLE));
    check("annul_stall", 64'(stall_o), 64'd0);
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    check("annul_result_kept", result_o, last_exp);

    // reset pulsed mid-ON clears everything asynchronously
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_state", 64'(state_o), 64'(IDLE));
    @(negedge clk);
    resetn = 1'b1;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("midrst_no_ready", 64'(ready_seen), 64'd0);
    run_div(32'd12345, 32'd7, 1'b0);

    // back-to-back with start held: one IDLE cycle between END and second ON
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    wait_ready(lat);
    check("b2b_first_lat", 64'(lat), 64'd33);
    check("b2b_first", result_o, 64'h00000000_00000003);
    opdata1_i = 32'd10; opdata2_i = 32'd4;
    @(negedge clk);
    check("b2b_idle_state", 64'(state_o), 64'(IDLE));
    check("b2b_idle_stall", 64'(stall_o), 64'd1);
    check("b2b_idle_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    check("b2b_on_state", 64'(state_o), 64'(ON));
    start_i = 1'b0;
    wait_ready(lat);
    check("b2b_second_lat", 64'(lat), 64'd32);
    check("b2b_second", result_o, 64'h00000002_00000002);
    @(negedge clk);
    check("b2b_pulse", 64'(ready_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
